// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter that drains a synchronous byte FIFO.
// Each frame is a start bit, DATA_WIDTH data bits LSB first and one stop bit,
// with every bit held for exactly CLKS_PER_BIT clocks. The FIFO read port is
// a registered BRAM with no empty guard, so a byte is only ever popped after
// i_fifo_empty=0 has been observed in IDLE, and the head word is captured one
// wait cycle (FETCH) later, when the BRAM output is known to be valid.
// All outputs are registered; they are computed from the next-state values so
// that they line up with the state they describe.

module uart_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                  o_fifo_rd_en,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    // Clocks per serial bit; must be at least 2 for the counter to make sense.
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q,  baud_d;
    logic [BIT_W-1:0]      bit_q,   bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  rd_en_q, rd_en_d;
    logic                  tx_q,    tx_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    logic                  bit_end;

    // The current bit period ends on the last count of the baud counter.
    assign bit_end = (baud_q == BAUD_LAST);

    // Next-state, counter and shift-register logic.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        rd_en_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!i_fifo_empty) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // BRAM output holds the head slot now: capture it and pop,
                // the pop strobe landing in the first START cycle.
                state_d = S_START;
                baud_d  = '0;
                shreg_d = i_fifo_rd_data;
                rd_en_d = 1'b1;
            end

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                end
            end

            default: begin
                // Unused encodings fall back to a clean idle.
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Registered output values derived from the state being entered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            rd_en_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            rd_en_q <= rd_en_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_fifo_rd_en = rd_en_q;
    assign o_tx         = tx_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at CLKS_PER_BIT=4.
// A queue-based FIFO model with a registered head-word output feeds the DUT;
// a line monitor decodes frames from o_tx by mid-bit sampling and records
// frame shape, o_done/o_busy behaviour and inter-frame idle gaps.

module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int FRAME = (DW + 2) * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty   = 1'b1;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       rd_en, tx, busy, done;

    logic       push      = 1'b0;
    logic [7:0] push_data = 8'h00;

    int total = 0;
    int bad   = 0;

    // FIFO model state
    byte unsigned fq[$];
    int pops = 0, pushes = 0, underflow = 0;

    // Line monitor state
    int           cyc = 0, k = 0, last_end = 0, starts = 0, done_cnt = 0;
    int           err_shape = 0, err_done = 0, err_busy = 0;
    bit           in_frame = 1'b0;
    logic         lvl = 1'b1;
    logic [7:0]   acc = 8'h00;
    byte unsigned rx_q[$];
    int           gaps[$];

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ_HZ(400),
        .BAUD       (100),
        .DATA_WIDTH (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_fifo_empty  (fifo_empty),
        .i_fifo_rd_data(fifo_rd_data),
        .o_fifo_rd_en  (rd_en),
        .o_tx          (tx),
        .o_busy        (busy),
        .o_done        (done)
    );

    // FIFO: pop on rd_en, push from stimulus, head word presented one clock later.
    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            pops++;
            if (fq.size() == 0) underflow++;
            else fq.delete(0);
        end
        if (push) begin
            fq.push_back(push_data);
            pushes++;
        end
        fifo_empty   <= (fq.size() == 0);
        fifo_rd_data <= (fq.size() != 0) ? fq[0] : 8'h00;
    end

    // Line monitor: decode 8N1 frames, check bit widths, o_done and o_busy.
    always @(negedge clk) begin
        int bidx, ph;
        cyc++;
        if (done === 1'b1) done_cnt++;
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                if (done !== 1'b0) err_done++;
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    k = 0;
                    starts++;
                    gaps.push_back(cyc - last_end - 1);
                end
            end
            if (in_frame) begin
                bidx = k / CPB;
                ph   = k % CPB;
                if (ph == 0) lvl = tx;
                else if (tx !== lvl) err_shape++;
                if (bidx == 0 && tx !== 1'b0) err_shape++;
                if (bidx == DW + 1 && tx !== 1'b1) err_shape++;
                if (bidx >= 1 && bidx <= DW && ph == CPB / 2) acc[bidx-1] = tx;
                if (busy !== 1'b1) err_busy++;
                if (done !== (k == FRAME - 1)) err_done++;
                if (k == FRAME - 1) begin
                    rx_q.push_back(acc);
                    in_frame = 1'b0;
                    last_end = cyc;
                end else begin
                    k++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic push_byte(input logic [7:0] b);
        push      = 1'b1;
        push_data = b;
        @(negedge clk);
        push      = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start"}, tx, 1'b0);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        int stable = 0;
        while (stable < 4 && n < limit) begin
            @(negedge clk);
            n++;
            if (fifo_empty && busy === 1'b0) stable++;
            else stable = 0;
        end
        check({tag, "_idle"}, (stable < 4), 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, p0, p1, d0, s0, errs;
        logic [63:0] got, exp;
        logic [7:0]  b;
        logic        lv;
        byte unsigned exp_q[$];
        byte unsigned t3[3];

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        rst_n = 1'b1;

        // 1: empty FIFO keeps the line idle and never pops
        errs = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) errs++;
        end
        check("t1_idle_line", errs, 0);
        check("t1_no_pop", pops, 0);

        // 2: single byte 0xA5, exact waveform
        p0 = pops; d0 = done_cnt; rx_q.delete();
        push_byte(8'hA5);
        n = 0;
        while (rd_en !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t2_rd_en_lat", n, 2);
        got = '0;
        for (int i = 0; i < FRAME; i++) begin
            got = {got[62:0], tx};
            @(negedge clk);
        end
        b = 8'hA5;
        exp = '0;
        for (int bi = 0; bi < DW + 2; bi++) begin
            lv = (bi == 0) ? 1'b0 : (bi == DW + 1) ? 1'b1 : b[bi-1];
            for (int p = 0; p < CPB; p++) exp = {exp[62:0], lv};
        end
        check("t2_wave", got, exp);
        wait_idle("t2", 200);
        check("t2_pops", pops - p0, 1);
        check("t2_done", done_cnt - d0, 1);
        check("t2_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) check("t2_rx", rx_q[0], 8'hA5);

        // 3: back-to-back bytes, two idle-high cycles between frames
        p0 = pops; rx_q.delete(); gaps.delete();
        t3[0] = 8'h00; t3[1] = 8'hFF; t3[2] = 8'h3C;
        for (int i = 0; i < 3; i++) push_byte(t3[i]);
        wait_idle("t3", 400);
        check("t3_pops", pops - p0, 3);
        check("t3_fifo_empty", fq.size(), 0);
        check("t3_rx_n", rx_q.size(), 3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) check("t3_rx", rx_q[i], t3[i]);
        check("t3_gaps_n", gaps.size(), 3);
        for (int i = 1; i < 3 && i < gaps.size(); i++) check("t3_gap", gaps[i], 2);

        // 4: reset during data bit 3 of 0x81
        p0 = pops; s0 = starts;
        push_byte(8'h81);
        wait_start("t4");
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_tx", tx, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check("t4_popped", pops - p0, 1);
        p1 = pops;
        errs = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) errs++;
        end
        check("t4_quiet", errs, 0);
        check("t4_no_pop", pops - p1, 0);
        check("t4_starts", starts - s0, 1);

        // 5: push during STOP of the previous frame
        p0 = pops; rx_q.delete(); gaps.delete();
        push_byte(8'h12);
        wait_start("t5");
        repeat (37) @(negedge clk);
        check("t5_in_stop", tx, 1'b1);
        push_byte(8'h55);
        wait_idle("t5", 300);
        check("t5_pops", pops - p0, 2);
        check("t5_rx_n", rx_q.size(), 2);
        if (rx_q.size() > 1) begin
            check("t5_rx0", rx_q[0], 8'h12);
            check("t5_rx1", rx_q[1], 8'h55);
        end
        check("t5_gaps_n", gaps.size(), 2);
        if (gaps.size() > 1) check("t5_gap", gaps[1], 2);

        // 6: random scoreboard
        p0 = pops; d0 = done_cnt; rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            push_byte(b);
            if ($urandom_range(0, 3) != 0) repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_idle("t6", 256 * FRAME * 2);
        check("t6_rx_n", rx_q.size(), 256);
        for (int i = 0; i < 256 && i < rx_q.size(); i++) check("t6_byte", rx_q[i], exp_q[i]);
        check("t6_pops", pops - p0, 256);
        check("t6_done", done_cnt - d0, 256);
        check("t6_pop_eq_push", pops - 1, pushes - 1);

        // Whole-run line and handshake checks
        check("frame_shape", err_shape, 0);
        check("done_pulse", err_done, 0);
        check("busy_in_frame", err_busy, 0);
        check("fifo_underflow", underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
